instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch stage of the rv32i core, directly upstream of immediate generation and decode. Maintains the PC, issues word requests to instruction memory over a request/grant bus with in-order responses, buffers returned words in a small FIFO, and presents `{pc, instr, imm_type}` to decode over a valid/ready handshake. `imm_type` is pre-decoded from the opcode, so the immediate generator receives its select already aligned with the instruction.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, instruction buffer entries; also the cap on outstanding plus buffered requests (power of two, ≥2)

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `imem_req`  out  1  fetch request valid
- `imem_addr`  out  32  word-aligned fetch address
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  response valid; in order, ≥1 cycle after grant
- `imem_rdata`  in  32  instruction word
- `redirect_valid`  in  1  branch/jump redirect
- `redirect_pc`  in  32  redirect target
- `out_valid`  out  1  instruction available
- `out_ready`  in  1  decode accepts
- `out_pc`  out  32  PC of `out_instr`
- `out_instr`  out  32  instruction word
- `out_imm_type`  out  3  001 I, 010 S, 011 B, 100 J, 000 none
- `misalign_err`  out  1  sticky misaligned-redirect flag (macro only)

## Operation
- FSM states: IDLE, RUN, DRAIN, HALT (HALT is present only with the macro).
- IDLE: entered on reset and held for one cycle; no request is issued. Then RUN.
- RUN: `imem_req`=1 while `outstanding + count < DEPTH`. On `imem_req && imem_gnt`: `fetch_pc += 4`, `outstanding++`. Each `imem_rvalid` decrements `outstanding` and pushes `{pc, rdata, imm_type}` into the FIFO. A grant and a response in the same cycle leave `outstanding` unchanged.
- Pop on `out_valid && out_ready`. Push and pop in the same cycle are allowed, including when the FIFO is full.
- imm_type decode from `instr[6:0]`:
  - 0010011, 0000011, 1100111 → 001
  - 0100011 → 010
  - 1100011 → 011
  - 1101111 → 100
  - all others → 000
- Redirect (highest priority, any state except HALT):
  - FIFO is flushed; any response arriving in the redirect cycle is dropped.
  - `fetch_pc <= redirect_pc`.
  - `discard <= outstanding` (including a grant in that cycle) minus any response in that cycle.
  - Next state is DRAIN if `discard != 0`, else RUN.
- DRAIN: no requests issued; each `imem_rvalid` decrements `discard` and the data is dropped. Go to RUN when the last discard arrives. A new redirect in DRAIN overwrites `fetch_pc` and accumulates into `discard`.
- Reset mid-operation clears all state immediately. Responses still in flight from before reset are outside this block's contract; memory must also be reset.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `out_valid`=0, `out_pc`/`out_instr`=0, `out_imm_type`=000, `misalign_err`=0.
- First request is raised in the 2nd cycle after `rst_n` rises.
- `imem_addr` equals `fetch_pc`; it is held stable while `imem_req && !imem_gnt`.
- Response-to-`out_valid` latency: 1 cycle (FIFO registered).
- With grant=1, response latency 1, and `out_ready`=1, the block sustains 1 instruction per cycle.
- `out_*` is stable while `out_valid && !out_ready`, except on redirect.
- `out_valid` drops the cycle after a redirect.

## Configuration
- `IFETCH_MISALIGN_CHK_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `misalign_err` and enters HALT. No requests are issued in HALT; `out_valid`=0.
  - HALT exits only through reset.
- Not defined:
  - `redirect_pc[1:0]` is ignored and forced to 00.
  - `misalign_err` is tied to 0.

## Structure
- Shared package `rv32i_pkg`: opcode constants, imm_type codes (IMM_NONE/I/S/B/J, matching the immediate generator's encoding), and the fetch-state enum.
- One sub-module, `fetch_fifo` (parameterised DEPTH, width 67, registered output, full/empty flags, synchronous flush).

## Test plan
- Reset release, gnt=1 → first `imem_addr`=0x0000_0000 in cycle 2 after reset release; addresses 0x0, 0x4, 0x8 on consecutive cycles.
- Latency-1 responses 0x00500093, 0x00A12023, `out_ready`=1 → out_pc 0x0/0x4, imm_type 001 then 010 on back-to-back cycles.
- `out_ready`=0 → after 2 grants `imem_req` drops, `out_*` holds; releasing `out_ready` resumes issue.
- Redirect to 0x100 with 2 outstanding → both late responses dropped; next `out_pc`=0x100.
- `instr`=0xFE000EE3 → `out_imm_type`=011; 0x0040006F → 100; 0x000000B7 → 000.
- Macro on, redirect to 0x102 → `misalign_err`=1, `imem_req`=0 until reset; macro off → next fetch address is 0x100.

Source files
------------

// File: rtl/rv32i_pkg.sv
// +----------------------------------------------------------------------------+
// | rv32i_pkg : opcodes, immediate-type codes and fetch-state encoding          |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package rv32i_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Encoding shared with the immediate generator's select input
  typedef enum logic [2:0] {
    IMM_NONE = 3'b000,
    IMM_I    = 3'b001,
    IMM_S    = 3'b010,
    IMM_B    = 3'b011,
    IMM_J    = 3'b100
  } imm_type_e;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_RUN   = 2'd1,
    FS_DRAIN = 2'd2,
    FS_HALT  = 2'd3
  } fetch_state_e;

  localparam int FETCH_ENTRY_W = 67;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  imm_type;
  } fetch_entry_t;

  function automatic logic [2:0] imm_type_of(input logic [6:0] opcode);
    case (opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: return IMM_I;
      OPC_STORE:                      return IMM_S;
      OPC_BRANCH:                     return IMM_B;
      OPC_JAL:                        return IMM_J;
      default:                        return IMM_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// +----------------------------------------------------------------------------+
// | instr_fetch_if : imem request/grant bus, redirect and decode handshake      |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface instr_fetch_if;
  import rv32i_pkg::*;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  out_imm_type;
  logic        misalign_err;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redirect_valid, redirect_pc,
    output out_valid,
    input  out_ready,
    output out_pc, out_instr, out_imm_type, misalign_err
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redirect_valid, redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_pc, out_instr, out_imm_type, misalign_err
  );

endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +----------------------------------------------------------------------------+
// | fetch_fifo : registered instruction buffer with synchronous flush           |
// | Revision   : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = FETCH_ENTRY_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign w_pop  = pop && !empty;
  // A full buffer still accepts a push when the head leaves in the same cycle
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == C_DEPTH);
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// +----------------------------------------------------------------------------+
// | instr_fetch : rv32i fetch stage (PC, imem bus, buffer, imm_type predecode)  |
// | Revision    : 1.0   Optional: IFETCH_MISALIGN_CHK_EN (misaligned -> HALT)    |
// +----------------------------------------------------------------------------+
`default_nettype none

module instr_fetch
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input logic           clk,
  input logic           rst_n,
  instr_fetch_if.master bus
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] C_DEPTH = (CW+1)'(DEPTH);

  localparam logic [1:0] C_IDLE  = FS_IDLE;
  localparam logic [1:0] C_RUN   = FS_RUN;
  localparam logic [1:0] C_DRAIN = FS_DRAIN;
`ifdef IFETCH_MISALIGN_CHK_EN
  localparam logic [1:0] C_HALT  = FS_HALT;
`endif

  logic [1:0]    r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;

  logic          w_gnt;
  logic          w_rsp;
  logic          w_pop;
  logic          w_push;
  logic          w_redirect;
  logic [31:0]   w_redirect_pc;
  logic [CW-1:0] w_discard_nxt;
  logic [CW:0]   w_occupancy;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

`ifdef IFETCH_MISALIGN_CHK_EN
  logic          w_misalign;
  logic          r_misalign_err;

  assign w_redirect = bus.redirect_valid && (r_state != C_HALT);
  assign w_misalign = w_redirect && (bus.redirect_pc[1:0] != 2'b00);
`else
  assign w_redirect = bus.redirect_valid;
`endif

  assign w_redirect_pc = bus.redirect_pc & ~32'h3;
  assign w_gnt         = bus.imem_req && bus.imem_gnt;
  assign w_rsp         = bus.imem_rvalid;
  assign w_pop         = bus.out_valid && bus.out_ready;
  assign w_push        = w_rsp && (r_state == C_RUN) && !w_redirect;

  // Credit the slot freed by this cycle's pop so latency-1 memory streams at 1/cycle
  assign w_occupancy   = {1'b0, r_outstanding} + {1'b0, w_count} - {{CW{1'b0}}, w_pop};
  assign bus.imem_req  = (r_state == C_RUN) && (!w_full || w_pop) && (w_occupancy < C_DEPTH);
  assign bus.imem_addr = r_fetch_pc;

  // Everything in flight at redirect time (including this cycle's grant) must be dropped
  assign w_discard_nxt = r_discard + r_outstanding + CW'(w_gnt) - CW'(w_rsp);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= C_IDLE;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else if (w_redirect) begin
      r_fetch_pc    <= w_redirect_pc;
      r_rsp_pc      <= w_redirect_pc;
      r_outstanding <= '0;
      r_discard     <= w_discard_nxt;
      r_state       <= (w_discard_nxt != '0) ? C_DRAIN : C_RUN;
`ifdef IFETCH_MISALIGN_CHK_EN
      if (w_misalign) begin
        r_state <= C_HALT;
      end
`endif
    end else begin
      case (r_state)
        C_IDLE: r_state <= C_RUN;
        C_RUN: begin
          if (w_gnt) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
          if (w_gnt && !w_rsp) begin
            r_outstanding <= r_outstanding + 1'b1;
          end else if (!w_gnt && w_rsp) begin
            r_outstanding <= r_outstanding - 1'b1;
          end
          if (w_push) begin
            r_rsp_pc <= r_rsp_pc + 32'd4;
          end
        end
        C_DRAIN: begin
          if (w_rsp) begin
            r_discard <= r_discard - 1'b1;
            if (r_discard == CW'(1)) begin
              r_state <= C_RUN;
            end
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

`ifdef IFETCH_MISALIGN_CHK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_misalign_err <= 1'b0;
    end else if (w_misalign) begin
      r_misalign_err <= 1'b1;
    end
  end

  assign bus.misalign_err = r_misalign_err;
`else
  assign bus.misalign_err = 1'b0;
`endif

  assign w_push_entry = '{pc:       r_rsp_pc,
                          instr:    bus.imem_rdata,
                          imm_type: imm_type_of(bus.imem_rdata[6:0])};

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FETCH_ENTRY_W)
  ) u_fetch_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (w_redirect),
    .push  (w_push),
    .din   (w_push_entry),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign bus.out_valid    = !w_empty;
  assign bus.out_pc       = w_head.pc;
  assign bus.out_instr    = w_head.instr;
  assign bus.out_imm_type = w_head.imm_type;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// +----------------------------------------------------------------------------+
// | tb_instr_fetch : directed bench for instr_fetch with a latency-1 imem model |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_instr_fetch;

  logic clk;
  logic rst_n;
  bit   rsp_hold;
  int   n_checks;
  int   n_errors;

  logic [31:0] pend_q[$];
  logic [2:0]  exp_imm [5];

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A1_2023;
      32'h0000_0008: return 32'hFE00_0EE3;
      32'h0000_000C: return 32'h0040_006F;
      32'h0000_0010: return 32'h0000_00B7;
      default:       return 32'h0000_0013;
    endcase
  endfunction

  // In-order memory: a grant seen in one cycle is answered in the next
  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_q.delete();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
      end else if (!rsp_hold && pend_q.size() > 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(pend_q.pop_front());
      end else begin
        bus.imem_rvalid = 1'b0;
      end
      #2;
      if (rst_n && bus.imem_req && bus.imem_gnt) begin
        pend_q.push_back(bus.imem_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    n_checks           = 0;
    n_errors           = 0;
    rsp_hold           = 1'b0;
    rst_n              = 1'b0;
    bus.imem_gnt       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    exp_imm            = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b000};

    // Reset values
    tick();
    tick();
    #1;
    chk("rst_req",      32'(bus.imem_req),     32'd0);
    chk("rst_addr",     bus.imem_addr,         32'h0);
    chk("rst_valid",    32'(bus.out_valid),    32'd0);
    chk("rst_pc",       bus.out_pc,            32'h0);
    chk("rst_instr",    bus.out_instr,         32'h0);
    chk("rst_imm",      32'(bus.out_imm_type), 32'd0);
    chk("rst_misalign", 32'(bus.misalign_err), 32'd0);

    // Release: cycle 1 is IDLE, first request in cycle 2
    tick();
    rst_n         = 1'b1;
    bus.imem_gnt  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("c1_req", 32'(bus.imem_req), 32'd0);
    tick(); #1;
    chk("c2_req",  32'(bus.imem_req), 32'd1);
    chk("c2_addr", bus.imem_addr,     32'h0);
    tick(); #1;
    chk("c3_addr",  bus.imem_addr,      32'h4);
    chk("c3_valid", 32'(bus.out_valid), 32'd0);
    chk("c3_instr", bus.out_instr,      32'h0);

    // Streaming at one instruction per cycle, predecode of each opcode class
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      chk("st_valid", 32'(bus.out_valid),    32'd1);
      chk("st_pc",    bus.out_pc,            32'(4 * k));
      chk("st_imm",   32'(bus.out_imm_type), 32'(exp_imm[k]));
      chk("st_addr",  bus.imem_addr,         32'(4 * (k + 2)));
    end
    chk("st_instr_lui", bus.out_instr, 32'h0000_00B7);

    // Backpressure: issue stops, head holds
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("bp_req0", 32'(bus.imem_req), 32'd0);
    chk("bp_pc0",  bus.out_pc,        32'h14);
    tick(); #1;
    chk("bp_req1",   32'(bus.imem_req),  32'd0);
    chk("bp_pc1",    bus.out_pc,         32'h14);
    chk("bp_valid1", 32'(bus.out_valid), 32'd1);
    tick();
    tick();
    bus.out_ready = 1'b1;
    #1;
    chk("bp_resume_req",  32'(bus.imem_req), 32'd1);
    chk("bp_resume_addr", bus.imem_addr,     32'h1C);
    tick(); #1;
    chk("bp_next_pc", bus.out_pc, 32'h18);

    // Redirect with a non-empty buffer and a grant in the same cycle
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    #1;
    chk("rd1_pre_pc", bus.out_pc, 32'h1C);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("rd1_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("rd1_drain_req",  32'(bus.imem_req),  32'd0);
    chk("rd1_addr",       bus.imem_addr,      32'h200);
    tick(); #1;
    chk("rd1_run_req",  32'(bus.imem_req), 32'd1);
    chk("rd1_run_addr", bus.imem_addr,     32'h200);
    tick();
    tick(); #1;
    chk("rd1_out_valid", 32'(bus.out_valid), 32'd1);
    chk("rd1_out_pc",    bus.out_pc,         32'h200);
    chk("rd1_out_instr", bus.out_instr,      32'h0000_0013);

    // Mid-run reset, then redirect with two responses still outstanding
    tick();
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(bus.out_valid), 32'd0);
    chk("mr_req",   32'(bus.imem_req),  32'd0);
    tick();
    tick();
    rsp_hold = 1'b1;
    rst_n    = 1'b1;
    tick();
    tick(); #1;
    chk("b_c3_addr", bus.imem_addr, 32'h4);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    rsp_hold           = 1'b0;
    #1;
    chk("b_full_req", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("b_drain_req0", 32'(bus.imem_req), 32'd0);
    chk("b_drain_addr", bus.imem_addr,     32'h100);
    tick(); #1;
    chk("b_drain_req1",  32'(bus.imem_req),  32'd0);
    chk("b_drain_valid", 32'(bus.out_valid), 32'd0);
    tick(); #1;
    chk("b_run_req",   32'(bus.imem_req),  32'd1);
    chk("b_run_addr",  bus.imem_addr,      32'h100);
    chk("b_run_valid", 32'(bus.out_valid), 32'd0);
    tick(); #1;
    chk("b_pre_valid", 32'(bus.out_valid), 32'd0);
    chk("b_next_addr", bus.imem_addr,      32'h104);
    tick(); #1;
    chk("b_out_valid", 32'(bus.out_valid), 32'd1);
    chk("b_out_pc",    bus.out_pc,         32'h100);
    chk("b_out_instr", bus.out_instr,      32'h0000_0013);

    // Misaligned redirect
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n              = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h102;
    #1;
    chk("m_idle_req", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
`ifdef IFETCH_MISALIGN_CHK_EN
    chk("m_err",  32'(bus.misalign_err), 32'd1);
    chk("m_req",  32'(bus.imem_req),     32'd0);
    tick();
    tick();
    tick(); #1;
    chk("m_halt_req",   32'(bus.imem_req),  32'd0);
    chk("m_halt_valid", 32'(bus.out_valid), 32'd0);
    chk("m_halt_err",   32'(bus.misalign_err), 32'd1);
`else
    chk("m_err",  32'(bus.misalign_err), 32'd0);
    chk("m_req",  32'(bus.imem_req),     32'd1);
    chk("m_addr", bus.imem_addr,         32'h100);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
